// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : gpio_pkg
//  Purpose : Shared types and constants for the GPIO pad controller slice.
//            Holds the per-pin mode encoding, the pin-count ceiling and a
//            helper that extracts one pin's mode from the packed mode word.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package gpio_pkg;

   // Upper bound on the number of pins a single controller instance handles.
   localparam int unsigned GPIO_MAX_IO = 16;

   // Two-bit per-pin mode. RSVD is decoded exactly like HIZ.
   typedef enum logic [1:0] {
      HIZ  = 2'b00,
      OUT  = 2'b01,
      IN   = 2'b10,
      RSVD = 2'b11
   } gpio_mode_e;

   // Mode of pin idx, taken from bits [2*idx+1:2*idx] of the mode word.
   function automatic gpio_mode_e pin_mode(input logic [31:0] ctrl,
                                           input int unsigned idx);
      return gpio_mode_e'(ctrl[2*idx +: 2]);
   endfunction

endpackage : gpio_pkg
`default_nettype wire

// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
//  Module  : gpio_debounce
//  Purpose : Two-flop synchronizer followed by a counting debouncer for one
//            pad input. The stable level only changes after the synchronized
//            input has disagreed with it for DEBOUNCE consecutive cycles.
//  Ports   : clk      in  clock, rising edge
//            rst      in  synchronous reset, active-low
//            pad_i    in  raw asynchronous pad input
//            level_o  out debounced stable level
//            chg_o    out high in the cycle whose closing edge flips level_o
//  Rev     : 1.0  initial release
// ============================================================================
module gpio_debounce #(
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic pad_i,
   output logic level_o,
   output logic chg_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE - 1);

   generate
      if (DEBOUNCE < 1 || DEBOUNCE > 65535) begin : g_bad_debounce
         $error("gpio_debounce: DEBOUNCE out of range 1..65535");
      end
   endgenerate

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic             st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // chg_o is combinational so the parent can register its edge flag on the
   // very edge that updates st.
   always_comb begin
      s1_d  = pad_i;
      s2_d  = s1_q;
      st_d  = st_q;
      cnt_d = cnt_q;
      chg_o = 1'b0;
      if (s2_q == st_q) begin
         // Any agreement restarts the run of disagreeing samples.
         cnt_d = '0;
      end else if (cnt_q == C_CNT_MAX) begin
         st_d  = s2_q;
         cnt_d = '0;
         chg_o = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         st_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         st_q  <= st_d;
         cnt_q <= cnt_d;
      end
   end

   assign level_o = st_q;

endmodule : gpio_debounce
`default_nettype wire

// File: rtl/gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : gpio_pad_ctrl
//  Purpose : Per-pin pad control for a GPIO block: registered output data and
//            output enable from the mode word, synchronized and debounced pin
//            input, and sticky edge-pending flags for pins in input mode.
//  Ports   : clk        in  clock, rising edge
//            rst        in  synchronous reset, active-low
//            reg_ctrl   in  [31:0] mode word, 2 bits per pin
//            reg_data   in  [31:0] output data, 1 bit per pin
//            io_pad_i   in  [NUM_IO-1:0] raw pad inputs
//            irq_clr_i  in  [NUM_IO-1:0] write-1-to-clear pending flags
//            io_pad_o   out [NUM_IO-1:0] pad output data
//            io_pad_oe  out [NUM_IO-1:0] pad output enable (1 = drive)
//            io_pin_o   out [NUM_IO-1:0] debounced pin level
//            irq_pend_o out [NUM_IO-1:0] pending edge flags
//            irq_o      out OR of all pending flags
//  Rev     : 1.0  initial release
// ============================================================================
module gpio_pad_ctrl
   import gpio_pkg::*;
#(
   parameter int unsigned NUM_IO   = 2,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       reg_ctrl,
   input  logic [31:0]       reg_data,
   input  logic [NUM_IO-1:0] io_pad_i,
   input  logic [NUM_IO-1:0] irq_clr_i,
   output logic [NUM_IO-1:0] io_pad_o,
   output logic [NUM_IO-1:0] io_pad_oe,
   output logic [NUM_IO-1:0] io_pin_o,
   output logic [NUM_IO-1:0] irq_pend_o,
   output logic              irq_o
);

   generate
      if (NUM_IO < 1 || NUM_IO > GPIO_MAX_IO) begin : g_bad_num_io
         $error("gpio_pad_ctrl: NUM_IO out of range 1..16");
      end
   endgenerate

   logic [NUM_IO-1:0] level_w;
   logic [NUM_IO-1:0] chg_w;

   // Input conditioning runs regardless of mode; mode only gates edge flags.
   generate
      for (genvar gi = 0; gi < NUM_IO; gi++) begin : g_pin
         gpio_debounce #(
            .DEBOUNCE (DEBOUNCE)
         ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .pad_i   (io_pad_i[gi]),
            .level_o (level_w[gi]),
            .chg_o   (chg_w[gi])
         );
      end
   endgenerate

   logic [NUM_IO-1:0] pad_o_q, pad_o_d;
   logic [NUM_IO-1:0] oe_q,    oe_d;
   logic [NUM_IO-1:0] pend_q,  pend_d;

   always_comb begin
      pad_o_d = '0;
      oe_d    = '0;
      pend_d  = '0;
      for (int unsigned i = 0; i < NUM_IO; i++) begin
         pad_o_d[i] = reg_data[i];
         // Only OUT drives; RSVD falls through with HIZ.
         oe_d[i]    = (pin_mode(reg_ctrl, i) == OUT);
         // The set term is ORed after the clear so a colliding edge wins.
         pend_d[i]  = (pend_q[i] & ~irq_clr_i[i])
                    | (chg_w[i] & (pin_mode(reg_ctrl, i) == IN));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pad_o_q <= '0;
         oe_q    <= '0;
         pend_q  <= '0;
      end else begin
         pad_o_q <= pad_o_d;
         oe_q    <= oe_d;
         pend_q  <= pend_d;
      end
   end

   // Mode/data bits beyond the last pin are intentionally ignored.
   logic unused_reg_bits;
   assign unused_reg_bits = ^{reg_ctrl, reg_data};

   assign io_pad_o   = pad_o_q;
   assign io_pad_oe  = oe_q;
   assign io_pin_o   = level_w;
   assign irq_pend_o = pend_q;
   assign irq_o      = |pend_q;

endmodule : gpio_pad_ctrl
`default_nettype wire

// File: tb/tb_gpio_pad_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_gpio_pad_ctrl
//  Purpose : Self-checking bench for gpio_pad_ctrl (NUM_IO = 2, DEBOUNCE = 4).
//            A window-based reference model predicts every output each cycle;
//            directed scenarios add literal expectations; a random phase
//            exercises modes, pads, clears and resets.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_gpio_pad_ctrl;

   localparam int N = 2;
   localparam int D = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   reg_ctrl;
   logic [31:0]   reg_data;
   logic [N-1:0]  io_pad_i;
   logic [N-1:0]  irq_clr_i;
   logic [N-1:0]  io_pad_o;
   logic [N-1:0]  io_pad_oe;
   logic [N-1:0]  io_pin_o;
   logic [N-1:0]  irq_pend_o;
   logic          irq_o;

   always #5 clk = ~clk;

   gpio_pad_ctrl #(
      .NUM_IO   (N),
      .DEBOUNCE (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .reg_ctrl   (reg_ctrl),
      .reg_data   (reg_data),
      .io_pad_i   (io_pad_i),
      .irq_clr_i  (irq_clr_i),
      .io_pad_o   (io_pad_o),
      .io_pad_oe  (io_pad_oe),
      .io_pin_o   (io_pin_o),
      .irq_pend_o (irq_pend_o),
      .irq_o      (irq_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference state. samp[i][j] is the pad value sampled j+1 edges ago, so
   // samp[i][1] is what the second synchronizer flop currently holds.
   logic [N-1:0] m_po, m_oe, m_st, m_pend;
   logic         m_samp [N][D+1];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one clock edge to the model, using the inputs present at the edge.
   task automatic model_edge();
      if (!rst) begin
         m_po = '0; m_oe = '0; m_st = '0; m_pend = '0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j <= D; j++) m_samp[i][j] = 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            logic all_diff;
            logic [1:0] mode;
            mode = reg_ctrl[2*i +: 2];
            // Level flips once the last D synchronized samples all disagree.
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
               if (m_samp[i][j] == m_st[i]) all_diff = 1'b0;
            if (all_diff) m_st[i] = ~m_st[i];
            m_pend[i] = (m_pend[i] & ~irq_clr_i[i]) | (all_diff & (mode == 2'b10));
            m_oe[i]   = (mode == 2'b01);
            m_po[i]   = reg_data[i];
            for (int j = D; j >= 1; j--) m_samp[i][j] = m_samp[i][j-1];
            m_samp[i][0] = io_pad_i[i];
         end
      end
   endtask

   // One cycle: edge, model update, then compare away from the edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("io_pad_o",   io_pad_o,   m_po);
      chk("io_pad_oe",  io_pad_oe,  m_oe);
      chk("io_pin_o",   io_pin_o,   m_st);
      chk("irq_pend_o", irq_pend_o, m_pend);
      chk("irq_o",      irq_o,      |m_pend);
   endtask

   initial begin
      int rst_left;

      // Reset held with pads high and both pins in output mode.
      rst = 1'b0; io_pad_i = 2'b11; reg_ctrl = 32'h5; reg_data = 32'h3;
      irq_clr_i = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rst_pad_o",  io_pad_o,   0);
         chk("rst_oe",     io_pad_oe,  0);
         chk("rst_pin",    io_pin_o,   0);
         chk("rst_pend",   irq_pend_o, 0);
         chk("rst_irq",    irq_o,      0);
      end

      // Output mode, then reserved mode.
      rst = 1'b1; io_pad_i = 2'b00; reg_ctrl = 32'h1; reg_data = 32'h1;
      step();
      chk("out_oe",   io_pad_oe,   2'b01);
      chk("out_pad0", io_pad_o[0], 1);
      reg_ctrl = 32'h3;
      step();
      chk("rsvd_oe",  io_pad_oe,   2'b00);

      // Input mode, settle.
      reg_ctrl = 32'h2; reg_data = 32'h0;
      for (int k = 0; k < 8; k++) step();

      // Rising edge held: appears exactly on the 6th edge.
      io_pad_i[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("rise_pin0",  io_pin_o[0],   (k == 6));
         chk("rise_pend0", irq_pend_o[0], (k == 6));
         chk("rise_irq",   irq_o,         (k == 6));
      end

      // Falling edge collides with a clear: set wins; lone clear then works.
      io_pad_i[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         irq_clr_i[0] = (k == 6);
         step();
         chk("fall_pin0",  io_pin_o[0],   (k < 6));
         chk("coll_pend0", irq_pend_o[0], 1);
      end
      irq_clr_i[0] = 1'b1;
      step();
      chk("clr_pend0", irq_pend_o[0], 0);
      chk("clr_irq",   irq_o,         0);
      irq_clr_i[0] = 1'b0;

      // Three-cycle glitch is rejected.
      io_pad_i[0] = 1'b1;
      for (int k = 0; k < 3; k++) step();
      io_pad_i[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("glitch_pin0",  io_pin_o[0],   0);
         chk("glitch_pend0", irq_pend_o[0], 0);
      end

      // Reset mid-count discards the partial run.
      io_pad_i[0] = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      chk("midrst_pin0", io_pin_o[0], 0);
      rst = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("midrst_rise_pin0", io_pin_o[0], (k == 6));
      end

      // Randomized phase: modes, data, pads, clears and occasional resets.
      rst_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (rst_left > 0) begin
            rst_left--;
            rst = (rst_left == 0);
         end else if ($urandom_range(0, 199) == 0) begin
            rst = 1'b0;
            rst_left = $urandom_range(1, 3);
         end
         if ($urandom_range(0, 19) == 0)
            reg_ctrl = {$urandom} & 32'hFFFF_FFF0 | {28'h0, 4'($urandom_range(0, 15))};
         reg_data = $urandom;
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) io_pad_i[i] = ~io_pad_i[i];
         irq_clr_i = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_gpio_pad_ctrl
`default_nettype wire
